// File: rtl/cdc_pkg.sv
// Shared constants and types for the clock-domain-crossing channels.
package cdc_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;

    // Index into the two-entry receive buffer; wraps 1 -> 0 by inversion.
    typedef logic ptr_t;

endpackage

// File: rtl/mcp_return_channel_if.sv
// Handshake bundle of the B->A return channel.
// slave  : the channel itself (accepts words from B, presents them to A).
// master : the surrounding logic (B producer plus A consumer).
interface mcp_return_channel_if #(
    parameter int WIDTH = 8
);
    logic             b_send;
    logic             b_ready;
    logic [WIDTH-1:0] b_datain;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_perr;

    modport master (
        output b_send, b_datain, a_ready,
        input  b_ready, a_valid, a_data, a_perr
    );

    modport slave (
        input  b_send, b_datain, a_ready,
        output b_ready, a_valid, a_data, a_perr
    );
endinterface

// File: rtl/mcp_return_channel_toggle_sync.sv
// Toggle-to-pulse synchronizer: SYNC_STAGES flop chain followed by an
// edge-detect register. The pulse is registered, so it appears
// SYNC_STAGES+1 destination edges after d_tog flips. q_tog is the
// synchronized copy of the toggle level.
module toggle_sync_pulse #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_tog,
    output logic pulse,
    output logic q_tog
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Synchronizer chain, edge-detect history and registered pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            q_tog  <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_tog};
            q_tog  <= sync_q[SYNC_STAGES-1];
            pulse  <= sync_q[SYNC_STAGES-1] ^ q_tog;
        end
    end

endmodule

// File: rtl/mcp_return_channel.sv
// B->A multi-cycle-path return channel with toggle handshake.
// The data word crosses unsynchronized; only the request/ack toggles are
// synchronized. A two-entry buffer on the A side lets the ack go back
// before the consumer drains, hiding one round trip.
// Optional feature macro: MCP_RETURN_PARITY_EN (even parity on the word,
// checked on capture, reported by a 1-cycle a_perr pulse).
module mcp_return_channel
    import cdc_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                 reset,
    input  logic                 clk_a,
    input  logic                 clk_b,
    mcp_return_channel_if.slave  bus
);

    // ---------------- B domain ----------------
    logic             b_busy;
    logic             b_tog;
    logic             b_ack;
    logic             b_transfer;
    logic [WIDTH-1:0] b_sample;
    logic             a_tog_seen_unused;

    // ---------------- A domain ----------------
    logic             a_tog;
    logic             arrive;
    logic             pop;
    logic             ack_now;
    logic             ack_pending;
    logic [1:0]       count;
    logic [1:0]       cnt_next;
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    logic [WIDTH-1:0] buffer [2];
    logic             b_tog_seen_unused;

    assign bus.b_ready = ~b_busy | b_ack;
    assign b_transfer  = bus.b_send & bus.b_ready;

    // B-side sample register and request toggle; busy until the ack returns.
    always_ff @(posedge clk_b or posedge reset) begin
        if (reset) begin
            b_busy   <= 1'b0;
            b_tog    <= 1'b0;
            b_sample <= RESET_VAL;
        end else if (b_transfer) begin
            b_busy   <= 1'b1;
            b_tog    <= ~b_tog;
            b_sample <= bus.b_datain;
        end else if (b_ack) begin
            b_busy   <= 1'b0;
        end
    end

    toggle_sync_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (clk_a),
        .reset (reset),
        .d_tog (b_tog),
        .pulse (arrive),
        .q_tog (b_tog_seen_unused)
    );

    toggle_sync_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk_b),
        .reset (reset),
        .d_tog (a_tog),
        .pulse (b_ack),
        .q_tog (a_tog_seen_unused)
    );

    assign pop         = bus.a_valid & bus.a_ready;
    assign bus.a_valid = (count != 2'd0);
    assign bus.a_data  = buffer[rd_ptr];

    // Occupancy after this edge, and whether the ack goes back now: either
    // an arrival that still leaves a free slot, or a pop freeing the slot a
    // deferred ack was waiting for.
    always_comb begin
        cnt_next = count + {1'b0, arrive} - {1'b0, pop};
        ack_now  = (arrive && (cnt_next != 2'd2)) || (ack_pending && pop);
    end

    // A-side buffer, pointers, occupancy and ack toggle.
    always_ff @(posedge clk_a or posedge reset) begin
        if (reset) begin
            buffer[0]   <= '0;
            buffer[1]   <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            a_tog       <= 1'b0;
            ack_pending <= 1'b0;
        end else begin
            if (arrive) begin
                buffer[wr_ptr] <= b_sample;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= cnt_next;
            if (ack_now) begin
                a_tog <= ~a_tog;
            end
            if (arrive && (cnt_next == 2'd2)) begin
                ack_pending <= 1'b1;
            end else if (ack_pending && pop) begin
                ack_pending <= 1'b0;
            end
        end
    end

    // A word can only arrive into a full buffer if a pop frees a slot at once.
    always @(posedge clk_a) begin
        if (!reset) begin
            assert (!(arrive && (count == 2'd2) && !pop));
        end
    end

`ifdef MCP_RETURN_PARITY_EN
    logic b_par;
    logic a_perr_q;

    // Even parity bit captured alongside the sample.
    always_ff @(posedge clk_b or posedge reset) begin
        if (reset) begin
            b_par <= ^RESET_VAL;
        end else if (b_transfer) begin
            b_par <= ^bus.b_datain;
        end
    end

    // Parity recheck on capture; pulse lines up with the buffered word.
    always_ff @(posedge clk_a or posedge reset) begin
        if (reset) begin
            a_perr_q <= 1'b0;
        end else begin
            a_perr_q <= arrive & ((^b_sample) ^ b_par);
        end
    end

    assign bus.a_perr = a_perr_q;
`else
    assign bus.a_perr = 1'b0;
`endif

endmodule
